// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the arithmetic datapath.
//   op_t     - opcode encoding (ADD, SUB, ADC, SBB)
//   flags_t  - NZCV flag bundle
//   sat_pos / sat_neg - signed saturation limits for a given width, returned
//   in a SAT_MAX_W-bit container; callers keep the low WIDTH bits.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBB = 2'b11
    } op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    localparam int SAT_MAX_W = 1024;

    // 100...0 (most negative value) in the low w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int w);
        sat_neg = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

    // 011...1 (most positive value) in the low w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int w);
        sat_pos = sat_neg(w) - {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// cla_chunk: combinational W-bit carry-lookahead slice.
//   a, b  - W-bit addends
//   cin   - carry into bit 0
//   s     - W-bit sum
//   cout  - carry out of the top bit
//   c_msb - carry into the top bit (used for signed overflow)
module cla_chunk
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         term;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly in g/p/cin (no ripple through c[i]):
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        c    = '0;
        term = 1'b0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            c[i+1] = cin;
            for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign s     = p ^ c[W-1:0];
    assign cout  = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per
// stage (NST = WIDTH/CHUNK stages, latency NST), NZCV flags, valid/ready.
//   clk, rst                    - clock, synchronous active-high reset
//   in_valid, in_ready          - input handshake
//   a, b, op, cin, sat          - operands, opcode (ADD/SUB/ADC/SBB), carry-in,
//                                 saturation request
//   out_valid, out_ready        - output handshake
//   y, flag_n/z/c/v             - result and flags (registered)
// Optional feature: define ADDSUB_SAT_EN to enable signed saturation when the
// beat's sat bit is set; otherwise sat is ignored.
module addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int NST = WIDTH / CHUNK;

`ifdef ADDSUB_SAT_EN
    localparam logic [SAT_MAX_W-1:0] SAT_POS_W = sat_pos(WIDTH);
    localparam logic [SAT_MAX_W-1:0] SAT_NEG_W = sat_neg(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_POS   = SAT_POS_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_NEG   = SAT_NEG_W[WIDTH-1:0];
`endif

    // One pipeline word. Operands travel the whole way so each stage can pick
    // its own slice; s fills in from the bottom one slice per stage.
    // f.c is the running carry and f.z the running all-zero bit; f.n and f.v
    // are only meaningful once the final stage has written them.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        op_t              op;
        logic             sat;
        flags_t           f;
    } stage_t;

    stage_t           stage_q [NST];
    stage_t           src     [NST];
    stage_t           nxt     [NST];
    logic [NST-1:0]   vld_pipe;
    logic [NST-1:0]   cmsb;
    stage_t           in_beat;
    op_t              op_e;
    logic             stall;

    assign op_e = op_t'(op);

    // Operand preparation: subtraction is a + ~b + carry-in (ARM-style
    // carry, C=1 means no borrow).
    always_comb begin
        in_beat     = '0;
        in_beat.a   = a;
        in_beat.b   = (op_e == OP_SUB || op_e == OP_SBB) ? ~b : b;
        in_beat.op  = op_e;
        in_beat.sat = sat;
        in_beat.f.z = 1'b1;
        case (op_e)
            OP_ADD:  in_beat.f.c = 1'b0;
            OP_SUB:  in_beat.f.c = 1'b1;
            default: in_beat.f.c = cin;
        endcase
    end

    for (genvar k = 0; k < NST; k++) begin : g_stage
        logic [CHUNK-1:0] s_k;
        logic             cout_k;
        stage_t           nxt_k;

        if (k == 0) begin : g_src_in
            assign src[k] = in_beat;
        end else begin : g_src_reg
            assign src[k] = stage_q[k-1];
        end

        cla_chunk #(.W(CHUNK)) u_cla (
            .a     (src[k].a[k*CHUNK +: CHUNK]),
            .b     (src[k].b[k*CHUNK +: CHUNK]),
            .cin   (src[k].f.c),
            .s     (s_k),
            .cout  (cout_k),
            .c_msb (cmsb[k])
        );

        always_comb begin
            nxt_k                      = src[k];
            nxt_k.s[k*CHUNK +: CHUNK]  = s_k;
            nxt_k.f.c                  = cout_k;
            nxt_k.f.z                  = src[k].f.z & ~(|s_k);
            if (k == NST - 1) begin
                nxt_k.f.n = s_k[CHUNK-1];
                nxt_k.f.v = cmsb[k] ^ cout_k;
`ifdef ADDSUB_SAT_EN
                // Clamp toward the sign of A; V and C keep the raw result.
                if (src[k].sat && (cmsb[k] ^ cout_k)) begin
                    nxt_k.s   = src[k].a[WIDTH-1] ? SAT_NEG : SAT_POS;
                    nxt_k.f.n = src[k].a[WIDTH-1];
                    nxt_k.f.z = 1'b0;
                end
`endif
            end
        end

        assign nxt[k] = nxt_k;
    end

    assign out_valid = vld_pipe[NST-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    // Stall freezes everything; otherwise every stage (bubbles included)
    // advances, and stage 0 captures the input beat when in_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < NST; k++) stage_q[k] <= '0;
        end else if (!stall) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k < NST; k++) vld_pipe[k] <= vld_pipe[k-1];
            for (int k = 0; k < NST; k++) stage_q[k] <= nxt[k];
        end
    end

    assign y      = stage_q[NST-1].s;
    assign flag_n = stage_q[NST-1].f.n;
    assign flag_z = stage_q[NST-1].f.z;
    assign flag_c = stage_q[NST-1].f.c;
    assign flag_v = stage_q[NST-1].f.v;

    // Operands, op and sat are dead once the last stage is written.
    logic unused_ok;
    assign unused_ok = ^{stage_q[NST-1].a, stage_q[NST-1].b,
                         stage_q[NST-1].op, stage_q[NST-1].sat, cmsb};

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed-vector bench for addsub_pipe. A 16/8 instance
// (latency 2) and a 32/8 instance (latency 4) are exercised; expected values
// are hand-computed constants. Expectations for saturating vectors follow
// ADDSUB_SAT_EN.
module tb_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  op;
    logic        cin;
    logic        sat;
    logic        out_ready;

    logic        in_valid16, in_ready16, out_valid16;
    logic [15:0] a16, b16, y16;
    logic        n16, z16, c16, v16;

    logic        in_valid32, in_ready32, out_valid32;
    logic [31:0] a32, b32, y32;
    logic        n32, z32, c32, v32;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] bp_exp [0:5];

    addsub_pipe #(.WIDTH(16), .CHUNK(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .op(op), .cin(cin), .sat(sat),
        .out_valid(out_valid16), .out_ready(out_ready), .y(y16),
        .flag_n(n16), .flag_z(z16), .flag_c(c16), .flag_v(v16)
    );

    addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .op(op), .cin(cin), .sat(sat),
        .out_valid(out_valid32), .out_ready(out_ready), .y(y32),
        .flag_n(n32), .flag_z(z32), .flag_c(c32), .flag_v(v32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat: checks acceptance, latency, y and NZCV.
    task automatic vec(input bit wide, input string tag, input logic [1:0] o,
                       input logic ci, input logic s, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ey,
                       input logic [3:0] ef);
        int lat;
        int exp_lat;
        op        = o;
        cin       = ci;
        sat       = s;
        out_ready = 1'b1;
        if (wide) begin
            a32 = va; b32 = vb; in_valid32 = 1'b1;
        end else begin
            a16 = va[15:0]; b16 = vb[15:0]; in_valid16 = 1'b1;
        end
        #1;
        chk({tag, "_rdy"}, wide ? in_ready32 : in_ready16, 64'd1);
        tick();
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        lat = 1;
        while (!(wide ? out_valid32 : out_valid16) && lat < 20) begin
            tick();
            lat++;
        end
        exp_lat = wide ? 4 : 2;
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (wide) begin
            chk({tag, "_y"}, 64'(y32), 64'(ey));
            chk({tag, "_nzcv"}, 64'({n32, z32, c32, v32}), 64'(ef));
        end else begin
            chk({tag, "_y"}, 64'(y16), 64'(ey[15:0]));
            chk({tag, "_nzcv"}, 64'({n16, z16, c16, v16}), 64'(ef));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        int got;

        bp_exp[0] = 16'h1010; bp_exp[1] = 16'h1011; bp_exp[2] = 16'h1012;
        bp_exp[3] = 16'h1013; bp_exp[4] = 16'h1014; bp_exp[5] = 16'h1015;

        rst = 1'b1; op = 2'b00; cin = 1'b0; sat = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0;
        in_valid32 = 1'b0; a32 = '0; b32 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ov16", 64'(out_valid16), 64'd0);
        chk("rst_y16", 64'(y16), 64'd0);
        chk("rst_f16", 64'({n16, z16, c16, v16}), 64'd0);
        chk("rst_rdy16", 64'(in_ready16), 64'd1);
        chk("rst_ov32", 64'(out_valid32), 64'd0);
        chk("rst_y32", 64'(y32), 64'd0);
        rst = 1'b0;
        tick();

        // 16-bit directed vectors
        vec(0, "add_carry_slice", 2'b00, 0, 0, 32'h00FF, 32'h0001, 32'h0100, 4'b0000);
`ifdef ADDSUB_SAT_EN
        vec(0, "add_ovf_sat",     2'b00, 0, 1, 32'h7FFF, 32'h0001, 32'h7FFF, 4'b0001);
        vec(0, "add_negovf_sat",  2'b00, 0, 1, 32'h8000, 32'hFFFF, 32'h8000, 4'b1011);
`else
        vec(0, "add_ovf_sat",     2'b00, 0, 1, 32'h7FFF, 32'h0001, 32'h8000, 4'b1001);
        vec(0, "add_negovf_sat",  2'b00, 0, 1, 32'h8000, 32'hFFFF, 32'h7FFF, 4'b0011);
`endif
        vec(0, "add_ovf_nosat",   2'b00, 0, 0, 32'h8000, 32'h8000, 32'h0000, 4'b0111);
        vec(0, "sub_equal",       2'b01, 0, 0, 32'h0005, 32'h0005, 32'h0000, 4'b0110);
        vec(0, "sub_borrow",      2'b01, 0, 0, 32'h0000, 32'h0001, 32'hFFFF, 4'b1000);
        vec(0, "adc_cross",       2'b10, 1, 0, 32'hFFFF, 32'h0000, 32'h0000, 4'b0110);
        vec(0, "sbb_borrow_in",   2'b11, 0, 0, 32'h0010, 32'h0001, 32'h000E, 4'b0010);

        // 32-bit sweep (latency 4)
        vec(1, "w32_add",         2'b00, 0, 0, 32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000);
        vec(1, "w32_add_ovf",     2'b00, 0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
        vec(1, "w32_sub_equal",   2'b01, 0, 0, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110);
        vec(1, "w32_sub_borrow",  2'b01, 0, 0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000);
        vec(1, "w32_adc_cross",   2'b10, 1, 0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b0110);

        // Backpressure: 6 back-to-back beats, out_ready low in cycles 3..6
        op = 2'b00; cin = 1'b0; sat = 1'b0;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            in_valid16 = (sent < 6);
            a16        = 16'h1000 + 16'(sent);
            b16        = 16'h0010;
            out_ready  = !(cyc >= 3 && cyc <= 6);
            #1;
            if (cyc >= 3 && cyc <= 6) begin
                chk($sformatf("bp_in_ready_c%0d", cyc), 64'(in_ready16), 64'd0);
                chk($sformatf("bp_ov_hold_c%0d", cyc), 64'(out_valid16), 64'd1);
                chk($sformatf("bp_y_stable_c%0d", cyc), 64'(y16), 64'(bp_exp[got]));
            end
            if (out_valid16 && out_ready) begin
                chk($sformatf("bp_y%0d", got), 64'(y16), 64'(bp_exp[got]));
                got++;
            end
            if (in_valid16 && in_ready16) sent++;
            @(posedge clk);
            #1;
        end
        in_valid16 = 1'b0;
        out_ready  = 1'b1;
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_got", 64'(got), 64'd6);
        tick();
        tick();
        chk("bp_no_dup", 64'(out_valid16), 64'd0);

        // Reset with two beats in flight and the output stalled
        op = 2'b00; out_ready = 1'b0;
        a16 = 16'h0001; b16 = 16'h0001; in_valid16 = 1'b1;
        tick();
        a16 = 16'h0002;
        tick();
        in_valid16 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_ov", 64'(out_valid16), 64'd0);
        chk("rst_mid_rdy", 64'(in_ready16), 64'd1);
        out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (out_valid16) seen++;
            end
            chk("rst_mid_no_emit", 64'(seen), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined adder/subtractor that generalises the team's 8-bit carry-lookahead adder. Operands of WIDTH bits are split into CHUNK-bit slices, and one slice is resolved per pipeline stage with a registered carry between stages. The block supports four opcodes (ADD, SUB, ADC, SBB), produces NZCV flags and uses a valid/ready handshake on both sides. It sits between the operand register file and the ALU result mux as the arithmetic datapath for wide operands.

## Interface
Parameters:
- WIDTH, default 16: operand and result width; must be a multiple of CHUNK.
- CHUNK, default 8: slice width per stage. Stage count is NST = WIDTH/CHUNK, and NST ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operand beat valid.
- in_ready, output, 1: block accepts a beat this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- op, input, 2: 00 ADD, 01 SUB, 10 ADC, 11 SBB.
- cin, input, 1: carry-in, used by ADC and SBB only.
- sat, input, 1: request signed saturation. Functional only with ADDSUB_SAT_EN.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- y, output, WIDTH: result.
- flag_n, output, 1: negative flag.
- flag_z, output, 1: zero flag.
- flag_c, output, 1: carry flag.
- flag_v, output, 1: overflow flag.

## Operation
- Operand preparation: for SUB and SBB, b is replaced by ~b. Effective carry-in is ADD→0, SUB→1, ADC→cin, SBB→cin. The carry convention is ARM-style: C=1 means no borrow.
- Stage k (0..NST-1) adds slice k of a and the prepared b with the incoming carry. Stage 0 takes the effective carry-in; stage k>0 takes the carry registered by stage k-1.
- Upper slices, op and sat travel skewed through the stage registers alongside the partial sum.
- Each stage also carries a running "all-zero-so-far" bit. flag_z is the AND of per-slice zero bits.
- The final stage computes the flags:
  - flag_c = carry out of the top slice.
  - flag_v = carry into the MSB XOR carry out of the MSB.
  - flag_n = y[WIDTH-1].
- Arithmetic is modulo 2^WIDTH. No width extension is performed.
- Handshake:
  - Accept a beat when in_valid && in_ready.
  - Deliver a result when out_valid && out_ready.
  - stall = out_valid && !out_ready. Stall freezes every stage register. in_ready = !stall.
  - Bubbles are not collapsed during stall, but bubbles do advance when not stalled.
- Ordering is strictly FIFO. At most NST results are in flight.
- The pipeline has no FSM. Per-stage valid bits form the only control state.

## Timing
- Latency is exactly NST cycles from acceptance to out_valid when there is no stall. With default parameters, latency is 2.
- Throughput is 1 beat per cycle when out_ready is held high.
- While stalled, y and all flags stay stable and out_valid stays high.
- Reset clears all stage valid bits. Because out_valid=0 after reset, in_ready=1 one cycle after reset.
- Reset values: y=0, all flags=0, out_valid=0. Operand and data stage registers also reset to 0.
- Reset mid-operation discards every in-flight beat. No partial result is emitted.
- Simultaneous accept and deliver in the same cycle is legal and required.
- An input beat presented during stall is not accepted. The source holds it.

## Configuration
- Macro: ADDSUB_SAT_EN.
- When defined and the beat's sat=1:
  - On signed overflow, y clamps to 0111…1 if the true result is positive (A's sign bit was 0), or to 1000…0 otherwise.
  - flag_v still reports the overflow.
  - flag_n and flag_z are recomputed from the clamped y.
  - flag_c is unchanged.
  - Saturation adds no latency and is applied in the final stage.
- When undefined: sat is ignored, y is always the modulo result, and no saturation logic is synthesised.

## Structure
- Shared package alu_pkg holds:
  - the opcode enum op_t (OP_ADD, OP_SUB, OP_ADC, OP_SBB);
  - the flag struct flags_t {n, z, c, v};
  - the saturation constants, as functions of WIDTH.
- Sub-module cla_chunk (parameter W) is a combinational W-bit carry-lookahead slice with inputs a, b and cin, and outputs s, cout, and c_msb (the carry into the top bit). It is instantiated once per stage.

## Test plan
Use WIDTH=16 and CHUNK=8 unless noted.
- ADD 0x00FF + 0x0001 → y=0x0100, NZCV=0000, out_valid exactly 2 cycles after accept.
- ADD 0x7FFF + 0x0001, sat=1 → without the macro, y=0x8000 and NZCV=1001. With ADDSUB_SAT_EN, y=0x7FFF and NZCV=0001.
- SUB 0x0005 − 0x0005 → y=0x0000, NZCV=0110. SUB 0x0000 − 0x0001 → y=0xFFFF, NZCV=1000.
- ADC with cin=1: 0xFFFF + 0x0000 → y=0x0000, NZCV=0110. This checks that the carry crosses the chunk boundary via the stage register.
- Backpressure:
  - Stimulus: 6 back-to-back beats; out_ready low for cycles 3–6.
  - in_ready must drop during stall.
  - All 6 results must appear in order, with no loss or duplication, and y must be stable while stalled.
- Reset mid-flight:
  - Stimulus: rst asserted for 1 cycle with 2 beats in flight.
  - No result may be emitted; out_valid=0 and in_ready=1 must hold on the next cycle.
  - Parameter sweep: repeat the directed ADD/SUB vectors with WIDTH=32, CHUNK=8, where latency must be 4.
